// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 device family on the controller's device bus.
package rc4_pkg;

  // Decryptor FSM states; every read is an address-drive state plus a WAIT state.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SI,
    ST_WAIT_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_XOR_WR,
    ST_DONE,
    ST_FAIL
  } dec_state_e;

  // Controller bus mode selects for the three devices sharing the S RAM.
  localparam logic [2:0] MODE_INIT    = 3'b001;
  localparam logic [2:0] MODE_SHUFFLE = 3'b010;
  localparam logic [2:0] MODE_DECRYPT = 3'b011;

  // Plaintext alphabet accepted by the early key-rejection check.
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

  // True for a space or a lowercase letter.
  function automatic logic is_plain_ascii(input logic [7:0] b);
    return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
  endfunction

endpackage

// File: rtl/ascii_checker.sv
// Flags whether a decrypted byte is plausible plaintext (space or a-z).
module ascii_checker
  import rc4_pkg::*;
(
  input  logic [7:0] data_in,
  output logic       valid
);

  // Purely combinational so a key-search sequencer can reuse it directly.
  always_comb begin
    valid = is_plain_ascii(data_in);
  end

endmodule

// File: rtl/ram_decryptor.sv
// RC4 keystream generator: swaps S[i]/S[j] per step and XORs the keystream
// with the encrypted ROM, writing plaintext into the result RAM.
module ram_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int MSG_LENGTH     = 32,
  parameter int MSG_ADDR_WIDTH = 5,
  parameter int CHECK_ASCII    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  output logic                      success,
  input  logic [RAM_WIDTH-1:0]      ram_out,
  output logic                      write_enable,
  output logic [RAM_WIDTH-1:0]      ram_in,
  output logic [RAM_WIDTH-1:0]      address,
  output logic [MSG_ADDR_WIDTH-1:0] rom_address,
  input  logic [7:0]                rom_q,
  output logic [MSG_ADDR_WIDTH-1:0] dec_address,
  output logic [7:0]                dec_data,
  output logic                      dec_wren
);

  localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

  dec_state_e                state_q, state_d;
  logic [RAM_WIDTH-1:0]      i_q, i_d;
  logic [RAM_WIDTH-1:0]      j_q, j_d;
  logic [RAM_WIDTH-1:0]      si_q, si_d;
  logic [RAM_WIDTH-1:0]      sj_q, sj_d;
  logic [RAM_WIDTH-1:0]      f_q, f_d;
  logic [MSG_ADDR_WIDTH-1:0] k_q, k_d;
  logic [7:0]                plain;
  logic                      plain_valid;

  // The keystream byte is captured leaving WAIT_F because the RAM output
  // moves on to address 0 during XOR_WR.
  always_comb begin
    plain = rom_q ^ f_q[7:0];
  end

  ascii_checker u_ascii_checker (
    .data_in(plain),
    .valid  (plain_valid)
  );

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      k_q     <= k_d;
    end
  end

  // Next-state, counter updates and per-state memory strobes.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    si_d         = si_q;
    sj_d         = sj_q;
    f_d          = f_q;
    k_d          = k_q;
    write_enable = 1'b0;
    ram_in       = '0;
    address      = '0;
    rom_address  = '0;
    dec_address  = '0;
    dec_data     = '0;
    dec_wren     = 1'b0;
    finished     = 1'b0;
    success      = 1'b0;

    if (state_q != ST_IDLE) begin
      rom_address = k_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = RAM_WIDTH'(1);
          j_d     = '0;
          k_d     = '0;
          state_d = ST_RD_SI;
        end
      end
      ST_RD_SI: begin
        address = i_q;
        state_d = ST_WAIT_SI;
      end
      ST_WAIT_SI: begin
        si_d    = ram_out;
        j_d     = j_q + ram_out;
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        address = j_q;
        state_d = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        sj_d    = ram_out;
        state_d = ST_WR_SI;
      end
      ST_WR_SI: begin
        address      = i_q;
        ram_in       = sj_q;
        write_enable = 1'b1;
        state_d      = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        address      = j_q;
        ram_in       = si_q;
        write_enable = 1'b1;
        state_d      = ST_RD_F;
      end
      ST_RD_F: begin
        address = si_q + sj_q;
        state_d = ST_WAIT_F;
      end
      ST_WAIT_F: begin
        f_d     = ram_out;
        state_d = ST_XOR_WR;
      end
      ST_XOR_WR: begin
        dec_address = k_q;
        dec_data    = plain;
        dec_wren    = 1'b1;
        if ((CHECK_ASCII != 0) && !plain_valid) begin
          state_d = ST_FAIL;
        end else if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MSG_ADDR_WIDTH'(1);
          i_d     = i_q + RAM_WIDTH'(1);
          state_d = ST_RD_SI;
        end
      end
      ST_DONE: begin
        finished = 1'b1;
        success  = 1'b1;
      end
      ST_FAIL: begin
        finished = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping start anywhere outside IDLE abandons the run and clears counters;
    // this is also how DONE/FAIL return to IDLE.
    if ((state_q != ST_IDLE) && !start) begin
      state_d = ST_IDLE;
      i_d     = '0;
      j_d     = '0;
      si_d    = '0;
      sj_d    = '0;
      f_d     = '0;
      k_d     = '0;
    end
  end

endmodule

// File: tb/tb_ram_decryptor.sv
// Bench for ram_decryptor: two instances (ASCII check on / off) with a short
// 3-byte message, a behavioural RC4 model and a per-cycle write comparator.
module tb_ram_decryptor;

   localparam int MSG_LEN = 3;
   localparam int AW      = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start       [2];
   logic          finished    [2];
   logic          success     [2];
   logic          writeEnable [2];
   logic          decWren     [2];
   logic [7:0]    ramOut      [2];
   logic [7:0]    ramIn       [2];
   logic [7:0]    address     [2];
   logic [7:0]    romQ        [2];
   logic [7:0]    decData     [2];
   logic [AW-1:0] romAddress  [2];
   logic [AW-1:0] decAddress  [2];

   logic [7:0]  sMem   [2][256];
   logic [7:0]  romMem [2][4];
   logic [7:0]  decMem [2][4];
   logic [7:0]  modelS [256];
   logic [7:0]  expKey [4];
   logic [15:0] expQ   [$];
   logic [15:0] expHead;
   bit          expOk;
   int          activeUnit;
   int          wrenCycles [$];
   int          checks = 0;
   int          errors = 0;

   ram_decryptor #(
      .RAM_WIDTH(8), .MSG_LENGTH(MSG_LEN), .MSG_ADDR_WIDTH(AW), .CHECK_ASCII(1)
   ) dutChecked (
      .clk(clk), .reset(reset), .start(start[0]), .finished(finished[0]),
      .success(success[0]), .ram_out(ramOut[0]), .write_enable(writeEnable[0]),
      .ram_in(ramIn[0]), .address(address[0]), .rom_address(romAddress[0]),
      .rom_q(romQ[0]), .dec_address(decAddress[0]), .dec_data(decData[0]),
      .dec_wren(decWren[0])
   );

   ram_decryptor #(
      .RAM_WIDTH(8), .MSG_LENGTH(MSG_LEN), .MSG_ADDR_WIDTH(AW), .CHECK_ASCII(0)
   ) dutUnchecked (
      .clk(clk), .reset(reset), .start(start[1]), .finished(finished[1]),
      .success(success[1]), .ram_out(ramOut[1]), .write_enable(writeEnable[1]),
      .ram_in(ramIn[1]), .address(address[1]), .rom_address(romAddress[1]),
      .rom_q(romQ[1]), .dec_address(decAddress[1]), .dec_data(decData[1]),
      .dec_wren(decWren[1])
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Synchronous 1-cycle-latency read ports of the S RAM and the ROM.
   always @(posedge clk) begin
      ramOut[0] <= sMem[0][address[0]];
      ramOut[1] <= sMem[1][address[1]];
      romQ[0]   <= romMem[0][romAddress[0]];
      romQ[1]   <= romMem[1][romAddress[1]];
   end

   // Write ports: strobes are stable mid-cycle and reads never coincide with
   // writes, so committing at the falling edge matches an edge-written RAM.
   always @(negedge clk) begin
      if (writeEnable[0]) sMem[0][address[0]] = ramIn[0];
      if (writeEnable[1]) sMem[1][address[1]] = ramIn[1];
      if (decWren[0]) decMem[0][decAddress[0]] = decData[0];
      if (decWren[1]) decMem[1][decAddress[1]] = decData[1];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   // Every result-RAM write must be the next one the model predicts; the idle
   // unit must stay silent on both memories.
   always @(negedge clk) begin
      if (reset) begin
         if (decWren[activeUnit]) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_dec_wren actual=addr %0d data %02h required=no write",
                        decAddress[activeUnit], decData[activeUnit]);
            end else begin
               expHead = expQ.pop_front();
               checkOutput("dec_address", 32'(decAddress[activeUnit]), 32'(expHead[15:8]));
               checkOutput("dec_data", 32'(decData[activeUnit]), 32'(expHead[7:0]));
            end
         end
         if (decWren[1-activeUnit] || writeEnable[1-activeUnit]) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_unit_write actual=write strobe required=none");
         end
      end
   end

   // Textbook RC4 PRGA over a copy of S; fills the expected write queue,
   // keystream, final S contents and pass/fail verdict.
   task automatic computeModel(input int u, input bit checkAscii);
      logic [7:0] s [256];
      logic [7:0] i, j, t, f, p;
      for (int x = 0; x < 256; x++) s[x] = sMem[u][x];
      i = 8'd0;
      j = 8'd0;
      expQ.delete();
      expOk = 1'b1;
      for (int k = 0; k < MSG_LEN; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         t = s[i] + s[j];
         f = s[t];
         p = romMem[u][k] ^ f;
         expKey[k] = f;
         expQ.push_back({8'(k), p});
         if (checkAscii && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7a))) begin
            expOk = 1'b0;
            break;
         end
      end
      for (int x = 0; x < 256; x++) modelS[x] = s[x];
   endtask

   task automatic setIdentity(input int u);
      for (int x = 0; x < 256; x++) sMem[u][x] = 8'(x);
      for (int k = 0; k < 4; k++) decMem[u][k] = 8'h00;
   endtask

   task automatic setRandomS(input int u);
      logic [7:0] t;
      int r;
      setIdentity(u);
      for (int x = 255; x > 0; x--) begin
         r = int'($urandom_range(x, 0));
         t = sMem[u][x]; sMem[u][x] = sMem[u][r]; sMem[u][r] = t;
      end
   endtask

   task automatic setRom(input int u, input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
      romMem[u][0] = r0;
      romMem[u][1] = r1;
      romMem[u][2] = r2;
      romMem[u][3] = 8'h00;
   endtask

   // Raises start just after an edge and runs until finished, recording the
   // cycle of each dec_wren; the IDLE cycle that samples start is cycle 1.
   task automatic applyStimulus(input int u);
      int cyc;
      bit done;
      activeUnit = u;
      wrenCycles.delete();
      @(posedge clk);
      #1 start[u] = 1'b1;
      cyc = 1;
      done = 1'b0;
      while (!done && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (decWren[u]) wrenCycles.push_back(cyc);
         if (finished[u]) done = 1'b1;
      end
      checkOutput("run_finished", 32'(done), 32'd1);
   endtask

   // Verdict, leftover writes, S RAM contents, hold while start stays high, release.
   task automatic finishRun(input int u);
      int diffs;
      diffs = 0;
      checkOutput("success", 32'(success[u]), 32'(expOk));
      checkOutput("writes_outstanding", 32'(expQ.size()), 32'd0);
      for (int x = 0; x < 256; x++) if (sMem[u][x] !== modelS[x]) diffs++;
      checkOutput("s_ram_diffs", 32'(diffs), 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("finished_hold", 32'(finished[u]), 32'd1);
      end
      start[u] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("finished_cleared", 32'(finished[u]), 32'd0);
      checkOutput("success_cleared", 32'(success[u]), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_finished"}, 32'(finished[0]), 32'd0);
      checkOutput({tag, "_success"}, 32'(success[0]), 32'd0);
      checkOutput({tag, "_write_enable"}, 32'(writeEnable[0]), 32'd0);
      checkOutput({tag, "_ram_in"}, 32'(ramIn[0]), 32'd0);
      checkOutput({tag, "_address"}, 32'(address[0]), 32'd0);
      checkOutput({tag, "_rom_address"}, 32'(romAddress[0]), 32'd0);
      checkOutput({tag, "_dec_wren"}, 32'(decWren[0]), 32'd0);
      checkOutput({tag, "_dec_address"}, 32'(decAddress[0]), 32'd0);
      checkOutput({tag, "_dec_data"}, 32'(decData[0]), 32'd0);
   endtask

   initial begin
      int cyc;
      int weCount;
      bit seenWren;
      logic [7:0] plain [3];
      int r;

      reset = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      activeUnit = 0;
      setIdentity(0);
      setIdentity(1);
      setRom(0, 8'h00, 8'h00, 8'h00);
      setRom(1, 8'h00, 8'h00, 8'h00);
      #2;
      checkAllZero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Identity S-box, ROM 63 25 66 -> "a a", keystream 02 05 07.
      setIdentity(0);
      setRom(0, 8'h63, 8'h25, 8'h66);
      computeModel(0, 1'b1);
      checkOutput("model_key0", 32'(expKey[0]), 32'h02);
      checkOutput("model_key1", 32'(expKey[1]), 32'h05);
      checkOutput("model_key2", 32'(expKey[2]), 32'h07);
      checkOutput("model_plain1", 32'(expQ[1][7:0]), 32'h20);
      applyStimulus(0);
      checkOutput("wren_count", 32'(wrenCycles.size()), 32'd3);
      if (wrenCycles.size() == 3) begin
         checkOutput("first_wren_cycle", 32'(wrenCycles[0]), 32'd10);
         checkOutput("wren_gap01", 32'(wrenCycles[1] - wrenCycles[0]), 32'd9);
         checkOutput("wren_gap12", 32'(wrenCycles[2] - wrenCycles[1]), 32'd9);
      end
      finishRun(0);
      checkOutput("dec_mem0", 32'(decMem[0][0]), 32'h61);
      checkOutput("dec_mem1", 32'(decMem[0][1]), 32'h20);
      checkOutput("dec_mem2", 32'(decMem[0][2]), 32'h61);
      checkOutput("s2", 32'(sMem[0][2]), 32'd3);
      checkOutput("s3", 32'(sMem[0][3]), 32'd5);
      checkOutput("s5", 32'(sMem[0][5]), 32'd2);

      // 'C' at k=1 with the check on: fails after the k=1 write.
      setIdentity(0);
      setRom(0, 8'h63, 8'h46, 8'h66);
      computeModel(0, 1'b1);
      checkOutput("model_fail_verdict", 32'(expOk), 32'd0);
      applyStimulus(0);
      checkOutput("fail_wren_count", 32'(wrenCycles.size()), 32'd2);
      finishRun(0);
      checkOutput("fail_dec_mem1", 32'(decMem[0][1]), 32'h43);
      checkOutput("fail_no_k2", 32'(decMem[0][2]), 32'h00);

      // Same message with the check off: completes.
      setIdentity(1);
      setRom(1, 8'h63, 8'h46, 8'h66);
      computeModel(1, 1'b0);
      applyStimulus(1);
      finishRun(1);
      checkOutput("nocheck_success_literal", 32'(expOk), 32'd1);
      checkOutput("nocheck_dec_mem1", 32'(decMem[1][1]), 32'h43);
      activeUnit = 0;

      // Abort by dropping start in WR_SJ of byte 1, then restart from k=0.
      setIdentity(0);
      setRom(0, 8'h63, 8'h25, 8'h66);
      computeModel(0, 1'b1);
      activeUnit = 0;
      @(posedge clk);
      #1 start[0] = 1'b1;
      cyc = 1;
      weCount = 0;
      seenWren = 1'b0;
      while (cyc < 100 && !(seenWren && weCount == 2)) begin
         @(posedge clk);
         #1;
         cyc++;
         if (decWren[0]) seenWren = 1'b1;
         else if (seenWren && writeEnable[0]) weCount++;
      end
      checkOutput("abort_reached_wr_sj", 32'(weCount), 32'd2);
      start[0] = 1'b0;
      expQ.delete();
      repeat (12) begin
         @(posedge clk);
         #1;
         checkOutput("abort_write_enable", 32'(writeEnable[0]), 32'd0);
         checkOutput("abort_rom_address", 32'(romAddress[0]), 32'd0);
      end
      setIdentity(0);
      computeModel(0, 1'b1);
      applyStimulus(0);
      if (wrenCycles.size() > 0) checkOutput("restart_first_wren", 32'(wrenCycles[0]), 32'd10);
      finishRun(0);
      checkOutput("restart_dec_mem0", 32'(decMem[0][0]), 32'h61);

      // Asynchronous reset during WAIT_F of byte 1 (cycle 18); RD_F is cycle 17.
      setIdentity(0);
      computeModel(0, 1'b1);
      @(posedge clk);
      #1 start[0] = 1'b1;
      cyc = 1;
      while (cyc < 18) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 17) checkOutput("rd_f_address", 32'(address[0]), 32'd5);
      end
      checkOutput("wait_f_rom_address", 32'(romAddress[0]), 32'd1);
      #2 reset = 1'b0;
      expQ.delete();
      #1;
      checkAllZero("midrun_reset");
      start[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_finished", 32'(finished[0]), 32'd0);

      // Random S permutations with mostly-valid plaintext on both units.
      for (int run = 0; run < 16; run++) begin
         int u;
         u = run % 2;
         setRandomS(u);
         setRom(u, 8'h00, 8'h00, 8'h00);
         computeModel(u, 1'b0);
         for (int k = 0; k < MSG_LEN; k++) begin
            if ($urandom_range(4, 0) == 0) plain[k] = 8'($urandom);
            else begin
               r = int'($urandom_range(26, 0));
               plain[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            end
         end
         setRom(u, plain[0] ^ expKey[0], plain[1] ^ expKey[1], plain[2] ^ expKey[2]);
         computeModel(u, u == 0);
         applyStimulus(u);
         finishRun(u);
      end
      activeUnit = 0;

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
